video_timing_gen: RTL and testbench

- Generates the pixel-clock-domain video timing (blk, hs, vs) and pixel coordinates that drive the RGB-to-HDMI encoder and the framebuffer read path.
- Sequences horizontal and vertical counters through the active, front porch, sync and back porch phases.
- Provides run/stop control with frame-aligned start and stop, plus frame and vblank event pulses for the CPU/interrupt logic.
- Sits in the GPU, clocked by the RGB pixel clock, directly upstream of the HDMI encoder.

---
 rtl/gpu_video_pkg.sv | 25 ++
 rtl/video_timing_gen_if.sv | 38 +++
 rtl/video_phase_counter.sv | 56 +++++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_video_pkg.sv
// Shared video timing definitions: FSM encoding, counter width and default 640x480 timing.
package gpu_video_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vt_state_e;

  function automatic int phase_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing bundle between the generator (master) and the HDMI encoder / fetch path (slave).
// Line-compare signals exist only when VIDEO_TIMING_GEN_LINE_IRQ_EN is defined.
interface video_timing_gen_if;
  import gpu_video_pkg::*;

  logic             en;
  logic             running;
  logic             blk;
  logic             hs;
  logic             vs;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frameStart;
  logic             vblankStart;
`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
  logic [CNT_W-1:0] lineCmp;
  logic             lineIrq;
`endif

  modport master (
    input  en,
`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
    input  lineCmp,
    output lineIrq,
`endif
    output running, blk, hs, vs, x, y, frameStart, vblankStart
  );

  modport slave (
    output en,
`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
    output lineCmp,
    input  lineIrq,
`endif
    input  running, blk, hs, vs, x, y, frameStart, vblankStart
  );

endinterface

// File: rtl/video_phase_counter.sv
// One timing axis (active/FP/sync/BP): wrap flag on the current count, flags decoded on the next count
// so the parent can register its outputs aligned with the counter. No backpressure.
module video_phase_counter
  import gpu_video_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             adv_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] nxt_cnt_o,
  output logic             wrap_o,
  output logic             nxt_active_o,
  output logic             nxt_sync_o
);

  localparam int EXT_W = CNT_W + 1;
  localparam int TOTAL = phase_total(ACTIVE, FP, SYNC, BP);
  localparam logic [EXT_W-1:0] LAST     = EXT_W'(TOTAL - 1);
  localparam logic [EXT_W-1:0] ACT_END  = EXT_W'(ACTIVE);
  localparam logic [EXT_W-1:0] SYNC_BEG = EXT_W'(ACTIVE + FP);
  localparam logic [EXT_W-1:0] SYNC_END = EXT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXT_W-1:0] cnt_ext;

  assign wrap_o = ({1'b0, cnt_q} == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Compared one bit wider so a phase ending exactly at 4096 still decodes correctly.
  assign cnt_ext      = {1'b0, cnt_d};
  assign nxt_cnt_o    = cnt_d;
  assign nxt_active_o = (cnt_ext < ACT_END);
  assign nxt_sync_o   = (cnt_ext >= SYNC_BEG) && (cnt_ext < SYNC_END);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing: frame-aligned run/stop, registered blk/hs/vs/x/y and event pulses, zero extra latency.
// No backpressure; VIDEO_TIMING_GEN_LINE_IRQ_EN adds the lineCmp/lineIrq line interrupt.
module video_timing_gen
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = phase_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = phase_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_VBLANK   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_range
    $error("H_TOTAL does not fit the pixel counter");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_range
    $error("V_TOTAL does not fit the line counter");
  end

  vt_state_e        state_q, state_d;
  logic             cnt_clr, h_adv, v_adv;
  logic             h_wrap, v_wrap, frame_end;
  logic [CNT_W-1:0] hcnt_d, vcnt_d;
  logic             h_act_d, v_act_d, h_sync_d, v_sync_d;
  logic             run_d, blk_d, hs_d, vs_d, frame_start_d, vblank_start_d;
  logic [CNT_W-1:0] x_d, y_d;
  logic             running_q, blk_q, hs_q, vs_q, frame_start_q, vblank_start_q;
  logic [CNT_W-1:0] x_q, y_q;

  assign cnt_clr   = (state_q == ST_IDLE);
  assign h_adv     = !cnt_clr;
  assign v_adv     = h_adv && h_wrap;
  assign frame_end = h_wrap && v_wrap;

  video_phase_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_hcnt (
    .clk(clk), .resetn(resetn), .adv_i(h_adv), .clr_i(cnt_clr),
    .nxt_cnt_o(hcnt_d), .wrap_o(h_wrap), .nxt_active_o(h_act_d), .nxt_sync_o(h_sync_d)
  );

  video_phase_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_vcnt (
    .clk(clk), .resetn(resetn), .adv_i(v_adv), .clr_i(cnt_clr),
    .nxt_cnt_o(vcnt_d), .wrap_o(v_wrap), .nxt_active_o(v_act_d), .nxt_sync_o(v_sync_d)
  );

  // Outputs are decoded from next-state values so the registered copies line up with the counters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (vif.en) state_d = ST_RUN;
      ST_RUN:      if (frame_end) state_d = vif.en ? ST_RUN : ST_IDLE;
                   else if (!vif.en) state_d = ST_STOPPING;
      ST_STOPPING: if (frame_end) state_d = vif.en ? ST_RUN : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    run_d          = (state_d != ST_IDLE);
    blk_d          = !(run_d && h_act_d && v_act_d);
    hs_d           = (run_d && h_sync_d) ? HS_POL : !HS_POL;
    vs_d           = (run_d && v_sync_d) ? VS_POL : !VS_POL;
    x_d            = blk_d ? '0 : hcnt_d;
    y_d            = blk_d ? '0 : vcnt_d;
    frame_start_d  = run_d && (hcnt_d == '0) && (vcnt_d == '0);
    vblank_start_d = run_d && (hcnt_d == H_VBLANK) && (vcnt_d == V_LAST_ACT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      running_q      <= 1'b0;
      blk_q          <= 1'b1;
      hs_q           <= !HS_POL;
      vs_q           <= !VS_POL;
      x_q            <= '0;
      y_q            <= '0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      running_q      <= run_d;
      blk_q          <= blk_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      x_q            <= x_d;
      y_q            <= y_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign vif.running     = running_q;
  assign vif.blk         = blk_q;
  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frameStart  = frame_start_q;
  assign vif.vblankStart = vblank_start_q;

`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
  logic line_irq_d, line_irq_q;

  // Out-of-range compare values can never match vcnt, so they never fire.
  assign line_irq_d = run_d && (hcnt_d == '0) && (vcnt_d == vif.lineCmp);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_irq_q <= 1'b0;
    end else begin
      line_irq_q <= line_irq_d;
    end
  end

  assign vif.lineIrq = line_irq_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-timing and default 640x480 instances against a frame-position model.
module tb_video_timing_gen;
  import gpu_video_pkg::*;

  localparam int SHA = 8, SHF = 2, SHS = 2, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
  localparam int S_HT = SHA + SHF + SHS + SHB;
  localparam int S_FRAME = S_HT * (SVA + SVF + SVS + SVB);
  localparam int D_HT = 800;
  localparam int D_FRAME = 800 * 525;

  typedef struct packed {
    logic        running;
    logic        blk;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        vbs;
  } out_t;

  localparam out_t RESET_OUT = {1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rstn_s = 1'b0;
  logic rstn_d = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if vif_s();
  video_timing_gen_if vif_d();

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_small (.clk(clk), .resetn(rstn_s), .vif(vif_s));

  video_timing_gen u_def (.clk(clk), .resetn(rstn_d), .vif(vif_d));

  int vectors = 0;
  int miscompares = 0;

  // Reference: a generator is either idle or at a linear position within the frame.
  // Frames always complete; whether another follows is decided by en on the last clock.
  bit ms_run, md_run;
  int ms_pos, md_pos;

  always @(posedge clk) begin
    if (!rstn_s) begin ms_run <= 1'b0; ms_pos <= 0; end
    else if (!ms_run || ms_pos == S_FRAME - 1) begin ms_run <= vif_s.en; ms_pos <= 0; end
    else ms_pos <= ms_pos + 1;

    if (!rstn_d) begin md_run <= 1'b0; md_pos <= 0; end
    else if (!md_run || md_pos == D_FRAME - 1) begin md_run <= vif_d.en; md_pos <= 0; end
    else md_pos <= md_pos + 1;
  end

  function automatic out_t model_out(bit run, int pos, int ha, int hf, int hsy, int hb,
                                     int va, int vf, int vsy);
    int ht = ha + hf + hsy + hb;
    int h = pos % ht;
    int v = pos / ht;
    out_t o;
    o.running = run;
    o.blk = !(run && h < ha && v < va);
    o.hs  = !(run && h >= ha + hf && h < ha + hf + hsy);
    o.vs  = !(run && v >= va + vf && v < va + vf + vsy);
    o.x   = o.blk ? 12'd0 : 12'(h);
    o.y   = o.blk ? 12'd0 : 12'(v);
    o.fs  = run && pos == 0;
    o.vbs = run && h == ha && v == va - 1;
    return o;
  endfunction

  function automatic out_t exp_s();
    return model_out(ms_run, ms_pos, SHA, SHF, SHS, SHB, SVA, SVF, SVS);
  endfunction

  function automatic out_t exp_d();
    return model_out(md_run, md_pos, 640, 16, 96, 48, 480, 10, 2);
  endfunction

  function automatic out_t got_s();
    return {vif_s.running, vif_s.blk, vif_s.hs, vif_s.vs, vif_s.x, vif_s.y,
            vif_s.frameStart, vif_s.vblankStart};
  endfunction

  function automatic out_t got_d();
    return {vif_d.running, vif_d.blk, vif_d.hs, vif_d.vs, vif_d.x, vif_d.y,
            vif_d.frameStart, vif_d.vblankStart};
  endfunction

  task automatic test_reset();
    rstn_s = 1'b0;
    vif_s.en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (got_s() !== RESET_OUT) begin
        miscompares++;
        $display("FAIL reset_hold got=%h exp=%h", got_s(), RESET_OUT);
      end
    end
    rstn_s = 1'b1;
    @(negedge clk);
    vectors++;
    if (vif_s.running !== 1'b1 || vif_s.frameStart !== 1'b1 || vif_s.blk !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_first_pixel got=%h exp=running,fs=1 blk=0", got_s());
    end
  endtask

  task automatic test_timing();
    int last_fs = 0;
    int n_fs = 0, n_act = 0, n_hs = 0, n_vs = 0;
    for (int i = 1; i <= 2 * S_FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (got_s() !== exp_s()) begin
        miscompares++;
        $display("FAIL timing pos=%0d got=%h exp=%h", ms_pos, got_s(), exp_s());
      end
      if (vif_s.frameStart === 1'b1) begin
        n_fs++;
        vectors++;
        if (i - last_fs != S_FRAME) begin
          miscompares++;
          $display("FAIL timing_fs_period got=%0d exp=%0d", i - last_fs, S_FRAME);
        end
        last_fs = i;
      end
      if (vif_s.blk === 1'b0) n_act++;
      if (vif_s.hs === 1'b0) n_hs++;
      if (vif_s.vs === 1'b0) n_vs++;
    end
    vectors++;
    if (n_fs != 2 || n_act != 64 || n_hs != 28 || n_vs != 28) begin
      miscompares++;
      $display("FAIL timing_counts got fs=%0d act=%0d hs=%0d vs=%0d exp 2/64/28/28",
               n_fs, n_act, n_hs, n_vs);
    end
  endtask

  task automatic test_mid_stop();
    int guard = 0;
    int n_run = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(ms_run && ms_pos == S_HT + 3) && guard < 200);
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL mid_stop_wait timeout got=%0d exp<200", guard);
    end
    vif_s.en = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      vectors++;
      if (got_s() !== exp_s()) begin
        miscompares++;
        $display("FAIL mid_stop pos=%0d got=%h exp=%h", ms_pos, got_s(), exp_s());
      end
      if (vif_s.running === 1'b1) n_run++;
    end while (vif_s.running === 1'b1 && guard < 150);
    vectors++;
    if (n_run != S_FRAME - (S_HT + 3) - 1) begin
      miscompares++;
      $display("FAIL mid_stop_tail got=%0d exp=%0d", n_run, S_FRAME - (S_HT + 3) - 1);
    end
    repeat (30) begin
      @(negedge clk);
      vectors++;
      if (vif_s.frameStart !== 1'b0 || got_s() !== RESET_OUT) begin
        miscompares++;
        $display("FAIL mid_stop_idle got=%h exp=%h", got_s(), RESET_OUT);
      end
    end
  endtask

  task automatic test_restart();
    int guard = 0;
    int cyc = 0;
    int r1 = $urandom_range(5, 40);
    int r2 = $urandom_range(1, 40);
    vif_s.en = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (vif_s.frameStart !== 1'b1 && guard < 5);
    vectors++;
    if (vif_s.frameStart !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_start got=%b exp=1", vif_s.frameStart);
    end
    do begin
      @(negedge clk);
      cyc++;
      vectors++;
      if (got_s() !== exp_s() || vif_s.running !== 1'b1) begin
        miscompares++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, got_s(), exp_s());
      end
      if (cyc == r1) vif_s.en = 1'b0;
      if (cyc == r1 + r2) vif_s.en = 1'b1;
    end while (vif_s.frameStart !== 1'b1 && cyc < 200);
    vectors++;
    if (cyc != S_FRAME) begin
      miscompares++;
      $display("FAIL restart_period got=%0d exp=%0d", cyc, S_FRAME);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors++;
      if (got_s() !== exp_s()) begin
        miscompares++;
        $display("FAIL random run=%0d pos=%0d got=%h exp=%h", ms_run, ms_pos, got_s(), exp_s());
      end
      vif_s.en = ($urandom_range(0, 9) < 6);
    end
    vif_s.en = 1'b1;
  endtask

  task automatic test_default();
    int max_x = 0, n_hs = 0, n_act = 0;
    rstn_d = 1'b0;
    vif_d.en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (got_d() !== RESET_OUT) begin
        miscompares++;
        $display("FAIL default_reset got=%h exp=%h", got_d(), RESET_OUT);
      end
    end
    rstn_d = 1'b1;
    for (int i = 0; i < 3 * D_HT; i++) begin
      @(negedge clk);
      vectors++;
      if (got_d() !== exp_d()) begin
        miscompares++;
        $display("FAIL default pos=%0d got=%h exp=%h", md_pos, got_d(), exp_d());
      end
      if (int'(vif_d.x) > max_x) max_x = int'(vif_d.x);
      if (vif_d.hs === 1'b0) n_hs++;
      if (vif_d.blk === 1'b0) n_act++;
    end
    vectors++;
    if (max_x != 639 || n_hs != 288 || n_act != 1920) begin
      miscompares++;
      $display("FAIL default_counts got x=%0d hs=%0d act=%0d exp 639/288/1920", max_x, n_hs, n_act);
    end
  endtask

`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
  task automatic test_line_irq();
    int guard = 0;
    int n_irq = 0;
    bit exp_irq;
    vif_s.en = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (vif_s.frameStart !== 1'b1 && guard < 200);
    vif_s.lineCmp = 12'd2;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      if (i == 2 * S_FRAME) vif_s.lineCmp = 12'd9;
      @(negedge clk);
      exp_irq = ms_run && (ms_pos % S_HT == 0) && (ms_pos / S_HT == int'(vif_s.lineCmp));
      vectors++;
      if (vif_s.lineIrq !== exp_irq) begin
        miscompares++;
        $display("FAIL line_irq pos=%0d cmp=%0d got=%b exp=%b", ms_pos, vif_s.lineCmp,
                 vif_s.lineIrq, exp_irq);
      end
      if (vif_s.lineIrq === 1'b1) n_irq++;
    end
    vectors++;
    if (n_irq != 2) begin
      miscompares++;
      $display("FAIL line_irq_count got=%0d exp=2", n_irq);
    end
  endtask
`endif

  initial begin
    vif_s.en = 1'b0;
    vif_d.en = 1'b0;
`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
    vif_s.lineCmp = 12'd0;
    vif_d.lineCmp = 12'd0;
`endif
    test_reset();
    test_timing();
    test_mid_stop();
    test_restart();
    test_random();
    test_default();
`ifdef VIDEO_TIMING_GEN_LINE_IRQ_EN
    test_line_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
